// File: rtl/seg_pair_encoder.sv
// Purpose: converts a 0..99 binary value to a two-digit seven-segment bus {tens, ones}; values above 99 show dash/dash.
// Latency: fixed 8 clocks from the accepting load edge to both7seg/done (7 shift/add-3 steps, then encode).
// Backpressure: none; load is accepted only in IDLE and ignored while busy (not queued), output held between conversions.
module seg_pair_encoder #(
    parameter bit BLANK_LZ   = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [6:0]  value,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [13:0] both7seg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    // Blank pattern as seen on the pins; the inverted form is used for common-anode displays.
    localparam logic [13:0] BLANK_PINS = ACTIVE_LOW ? 14'h3FFF : 14'h0000;
    localparam logic [6:0]  DASH       = 7'h40;

    state_t      state, state_nxt;
    logic [6:0]  shreg, shreg_nxt;
    logic [6:0]  cap, cap_nxt;
    logic [7:0]  bcd, bcd_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        busy_nxt, done_nxt, ovf_nxt;
    logic [13:0] seg_nxt;

    logic [7:0]  bcd_adj;
    logic [14:0] shifted;
    logic [6:0]  tens_pat, ones_pat;
    logic [13:0] seg_enc;

    // Active-high a..g pattern (bit0 = a) for one BCD digit; non-decimal codes render blank.
    function automatic logic [6:0] digit_pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Double-dabble step: add 3 to any nibble >= 5, then shift {bcd, shreg} left by one.
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        shifted = {bcd_adj, shreg} << 1;
    end

    // Final pattern from the finished BCD digits, with overflow dashes, leading-zero blanking and polarity.
    always_comb begin
        tens_pat = digit_pat(bcd[7:4]);
        ones_pat = digit_pat(bcd[3:0]);
        if (BLANK_LZ && (bcd[7:4] == 4'd0)) tens_pat = 7'h00;
        if (cap > 7'd99) begin
            tens_pat = DASH;
            ones_pat = DASH;
        end
        seg_enc = ACTIVE_LOW ? ~{tens_pat, ones_pat} : {tens_pat, ones_pat};
    end

    // Next-state and datapath updates; everything holds unless the current state says otherwise.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cap_nxt   = cap;
        bcd_nxt   = bcd;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        ovf_nxt   = ovf;
        seg_nxt   = both7seg;
        case (state)
            IDLE: begin
                if (load) begin
                    shreg_nxt = value;
                    cap_nxt   = value;
                    bcd_nxt   = 8'h00;
                    cnt_nxt   = 3'd7;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt   = shifted[14:7];
                shreg_nxt = shifted[6:0];
                cnt_nxt   = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = ENCODE;
            end
            ENCODE: begin
                seg_nxt   = seg_enc;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                ovf_nxt   = (cap > 7'd99);
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion and blanks the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= 7'h00;
            cap      <= 7'h00;
            bcd      <= 8'h00;
            cnt      <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            both7seg <= BLANK_PINS;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            cap      <= cap_nxt;
            bcd      <= bcd_nxt;
            cnt      <= cnt_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            ovf      <= ovf_nxt;
            both7seg <= seg_nxt;
        end
    end

endmodule
